// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Multi-cycle unsigned subtractor: o_d = i_a - i_b - i_borrow_in (mod 2^N).
//   Each RUN cycle handles one W-bit chunk, LSB first. A registered borrow links
//   the chunks, so o_valid rises N/W cycles after the accept edge. Only one
//   operation is in flight at a time, and valid/ready handshakes sit on both sides.
//
//   Parameters: N operand width (must be a multiple of W), W chunk width.
//   Ports:
//     i_clk, i_rst_n          clock (rising edge); async active-low reset
//     i_valid / o_ready       operand handshake (o_ready high only in IDLE)
//     i_a, i_b, i_borrow_in   minuend, subtrahend, borrow into bit 0
//     o_valid / i_ready       result handshake (result held while i_ready=0)
//     o_d, o_borrow_out       difference and final borrow (1 iff a < b + bin)
//   Optional (macro SERIAL_SUBTRACTOR_FLAGS_EN):
//     o_zero                  o_d == 0, built up one chunk at a time
//     o_overflow              signed overflow of the subtraction
module serial_subtractor #(
  parameter int unsigned N = 64,
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_borrow_in,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_d,
  output logic         o_borrow_out
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
  ,
  output logic         o_zero,
  output logic         o_overflow
`endif
);

  localparam int unsigned NCHUNK = N / W;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state_q;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [CW-1:0] cnt_q;
  logic          borrow_q;
  logic [W-1:0]  a_chunk;
  logic [W-1:0]  b_chunk;
  logic [W:0]    diff;

  // The extra top bit of the (W+1)-bit difference is the borrow out of this chunk.
  always_comb begin
    a_chunk = a_q[cnt_q*W +: W];
    b_chunk = b_q[cnt_q*W +: W];
    diff    = {1'b0, a_chunk} - {1'b0, b_chunk} - {{W{1'b0}}, borrow_q};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      o_ready      <= 1'b1;
      o_valid      <= 1'b0;
      o_d          <= '0;
      o_borrow_out <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      cnt_q        <= '0;
      borrow_q     <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
      o_zero       <= 1'b0;
      o_overflow   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_valid && o_ready) begin
            a_q      <= i_a;
            b_q      <= i_b;
            borrow_q <= i_borrow_in;
            cnt_q    <= '0;
            o_ready  <= 1'b0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          // o_d is filled in place chunk by chunk; it is only meaningful once o_valid rises.
          o_d[cnt_q*W +: W] <= diff[W-1:0];
          borrow_q          <= diff[W];
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
          o_zero <= ((cnt_q == '0) ? 1'b1 : o_zero) & (diff[W-1:0] == '0);
`endif
          if (cnt_q == LAST) begin
            o_borrow_out <= diff[W];
            o_valid      <= 1'b1;
            state_q      <= DONE;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
            o_overflow   <= (a_q[N-1] != b_q[N-1]) && (diff[W-1] != a_q[N-1]);
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          // o_ready comes back one cycle after the result handshake, so it is registered.
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          o_ready <= 1'b1;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [63:0] d;
    logic        bo;
    logic        z;
    logic        ov;
  } exp_t;

  // Reference: unsigned result and borrow from whole-number arithmetic; overflow
  // means the exact signed result does not fit in 64 bits.
  function automatic exp_t ref_sub(input logic [63:0] a, input logic [63:0] b, input logic bin);
    exp_t e;
    logic signed [65:0] sr;
    e.d  = a - b - 64'(bin);
    e.bo = ({1'b0, a} < ({1'b0, b} + 65'(bin)));
    e.z  = (e.d == 64'd0);
    sr   = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b}) - $signed({65'd0, bin});
    e.ov = !((sr[65:63] == 3'b000) || (sr[65:63] == 3'b111));
    return e;
  endfunction

  task automatic rand_ops(output logic [63:0] a, output logic [63:0] b, output logic bin);
    int unsigned sel;
    sel = $urandom_range(0, 7);
    a   = {$urandom, $urandom};
    b   = {$urandom, $urandom};
    bin = 1'($urandom_range(0, 1));
    case (sel)
      0: b = a;
      1: a = '0;
      2: a = '1;
      3: b = '1;
      default: ;
    endcase
  endtask

  // ---------------- directed DUT (N=64, W=8) ----------------
  logic        m_rst_n = 1'b0;
  logic        m_valid = 1'b0;
  logic        m_ready = 1'b1;
  logic        m_bin   = 1'b0;
  logic [63:0] m_a     = '0;
  logic [63:0] m_b     = '0;
  logic        m_o_ready, m_o_valid, m_bo;
  logic [63:0] m_d;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
  logic        m_z, m_ov;
`endif

  serial_subtractor #(.N(64), .W(8)) u_dut (
    .i_clk        (clk),
    .i_rst_n      (m_rst_n),
    .i_valid      (m_valid),
    .o_ready      (m_o_ready),
    .i_a          (m_a),
    .i_b          (m_b),
    .i_borrow_in  (m_bin),
    .o_valid      (m_o_valid),
    .i_ready      (m_ready),
    .o_d          (m_d),
    .o_borrow_out (m_bo)
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
    ,
    .o_zero       (m_z),
    .o_overflow   (m_ov)
`endif
  );

  // Called at posedge+1. Returns at posedge+1 of the edge where o_valid rose.
  // While busy, operands are scrambled and i_valid toggled; neither may matter.
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic bin,
                      output int lat, output bit ok);
    m_a = a; m_b = b; m_bin = bin; m_valid = 1'b1;
    ok  = 1'b0;
    lat = 0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      ok = m_o_ready;
      @(posedge clk); #1;
    end
    if (!ok) return;
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      chk("busy o_ready", m_o_ready, 1'b0);
      m_a     = {$urandom, $urandom};
      m_b     = {$urandom, $urandom};
      m_bin   = 1'($urandom_range(0, 1));
      m_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
      ok = m_o_valid;
    end
    m_valid = 1'b0;
  endtask

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        bin;
    logic [63:0] d;
    logic        bo;
    logic        z;
    logic        ov;
  } vec_t;

  vec_t vecs[7];

  task automatic check_result(input string nm, input vec_t v);
    chk({nm, " d"}, m_d, v.d);
    chk({nm, " borrow"}, m_bo, v.bo);
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
    chk({nm, " zero"}, m_z, v.z);
    chk({nm, " ovf"}, m_ov, v.ov);
`endif
  endtask

  // ---------------- random DUTs, W in {1,8,64} ----------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_rand
    localparam int unsigned GW     = (gi == 0) ? 1 : (gi == 1) ? 8 : 64;
    localparam int          NOPS   = (GW == 1) ? 300 : 1000;
    localparam int          BUDGET = NOPS * (64 / GW + 10) + 200;

    logic        r_rst_n = 1'b0;
    logic        r_valid = 1'b0;
    logic        r_ready = 1'b0;
    logic        r_bin   = 1'b0;
    logic [63:0] r_a     = '0;
    logic [63:0] r_b     = '0;
    logic        r_o_ready, r_o_valid, r_bo;
    logic [63:0] r_d;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
    logic        r_z, r_ov;
`endif
    exp_t        exp_q[$];
    int          accepted  = 0;
    int          completed = 0;
    bit          fin       = 1'b0;
    string       tag;

    serial_subtractor #(.N(64), .W(GW)) u_rdut (
      .i_clk        (clk),
      .i_rst_n      (r_rst_n),
      .i_valid      (r_valid),
      .o_ready      (r_o_ready),
      .i_a          (r_a),
      .i_b          (r_b),
      .i_borrow_in  (r_bin),
      .o_valid      (r_o_valid),
      .i_ready      (r_ready),
      .o_d          (r_d),
      .o_borrow_out (r_bo)
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
      ,
      .o_zero       (r_z),
      .o_overflow   (r_ov)
`endif
    );

    initial begin : producer
      logic [63:0] a, b;
      logic        bin;
      bit          acc;
      tag = $sformatf("W%0d", GW);
      repeat (3) @(negedge clk);
      r_rst_n = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < NOPS; k++) begin
        repeat ($urandom_range(0, 2)) begin
          r_valid = 1'b0;
          r_a = {$urandom, $urandom};
          r_b = {$urandom, $urandom};
          @(posedge clk); #1;
        end
        rand_ops(a, b, bin);
        r_a = a; r_b = b; r_bin = bin; r_valid = 1'b1;
        acc = 1'b0;
        for (int t = 0; t < 300 && !acc; t++) begin
          @(negedge clk);
          acc = r_o_ready;
          @(posedge clk); #1;
        end
        chk({tag, " accept within bound"}, acc, 1'b1);
        if (!acc) break;
        exp_q.push_back(ref_sub(a, b, bin));
        accepted++;
        r_valid = 1'b0;
        r_a = {$urandom, $urandom};
        r_b = {$urandom, $urandom};
      end
    end

    initial begin : consumer
      exp_t        e;
      logic [63:0] pd;
      logic        pbo;
      bit          stalled;
      stalled = 1'b0;
      pd      = '0;
      pbo     = 1'b0;
      for (int c = 0; c < BUDGET && completed < NOPS; c++) begin
        @(posedge clk); #1;
        r_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (r_o_valid && r_o_ready) chk({tag, " ready&valid both high"}, 1'b1, 1'b0);
        if (stalled) begin
          chk({tag, " held valid"}, r_o_valid, 1'b1);
          chk({tag, " held d"}, r_d, pd);
          chk({tag, " held borrow"}, r_bo, pbo);
        end
        if (r_o_valid && r_ready) begin
          if (exp_q.size() == 0) begin
            chk({tag, " unexpected result"}, 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            chk({tag, " d"}, r_d, e.d);
            chk({tag, " borrow"}, r_bo, e.bo);
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
            chk({tag, " zero"}, r_z, e.z);
            chk({tag, " ovf"}, r_ov, e.ov);
`endif
          end
          completed++;
        end
        stalled = r_o_valid && !r_ready;
        pd      = r_d;
        pbo     = r_bo;
      end
      chk({tag, " ops completed"}, 64'(completed), 64'(NOPS));
      chk({tag, " ops accepted"}, 64'(accepted), 64'(NOPS));
      chk({tag, " none pending"}, 64'(exp_q.size()), 64'd0);
      fin = 1'b1;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin : main
    int lat;
    bit ok;
    vec_t v;

    vecs[0] = '{64'd10, 64'd3, 1'b0, 64'd7, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{64'h0000_0000_0000_0100, 64'd1, 1'b0, 64'h0000_0000_0000_00FF, 1'b0, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    chk("reset o_ready", m_o_ready, 1'b1);
    chk("reset o_valid", m_o_valid, 1'b0);
    chk("reset o_d", m_d, 64'd0);
    chk("reset borrow", m_bo, 1'b0);
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
    chk("reset zero", m_z, 1'b0);
    chk("reset ovf", m_ov, 1'b0);
`endif
    m_rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].bin, lat, ok);
      chk($sformatf("vec%0d valid seen", i), ok, 1'b1);
      chk($sformatf("vec%0d latency", i), 64'(lat), 64'd8);
      check_result($sformatf("vec%0d", i), vecs[i]);
      @(posedge clk); #1;
      chk($sformatf("vec%0d post o_valid", i), m_o_valid, 1'b0);
      chk($sformatf("vec%0d post o_ready", i), m_o_ready, 1'b1);
    end

    // Equal operands, then backpressure for 5 cycles.
    v = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0};
    m_ready = 1'b0;
    send(v.a, v.b, v.bin, lat, ok);
    chk("eq valid seen", ok, 1'b1);
    chk("eq latency", 64'(lat), 64'd8);
    check_result("eq", v);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("stall o_valid", m_o_valid, 1'b1);
      chk("stall o_ready", m_o_ready, 1'b0);
      check_result("stall", v);
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall release o_valid", m_o_valid, 1'b0);
    chk("stall release o_ready", m_o_ready, 1'b1);

    // Reset in the middle of RUN, then a clean operation.
    m_a = 64'hDEAD_BEEF_0000_1111; m_b = 64'h0123_4567_89AB_CDEF; m_bin = 1'b1; m_valid = 1'b1;
    @(posedge clk); #1;
    m_valid = 1'b0;
    chk("abort accepted", m_o_ready, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("abort pre o_valid", m_o_valid, 1'b0);
    m_rst_n = 1'b0;
    #1;
    chk("abort o_valid", m_o_valid, 1'b0);
    chk("abort o_ready", m_o_ready, 1'b1);
    chk("abort o_d", m_d, 64'd0);
    chk("abort borrow", m_bo, 1'b0);
    @(negedge clk);
    m_rst_n = 1'b1;
    @(posedge clk); #1;
    v = '{64'd5, 64'd2, 1'b0, 64'd3, 1'b0, 1'b0, 1'b0};
    send(v.a, v.b, v.bin, lat, ok);
    chk("after abort valid seen", ok, 1'b1);
    chk("after abort latency", 64'(lat), 64'd8);
    check_result("after abort", v);
    @(posedge clk); #1;

    ok = 1'b0;
    for (int c = 0; c < 90000 && !ok; c++) begin
      @(posedge clk);
      ok = g_rand[0].fin && g_rand[1].fin && g_rand[2].fin;
    end
    chk("random runs finished", ok, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
